source_ctrl: RTL
================

// Module: source_ctrl
//
// PURPOSE
// Drives the SOURCE excitation generator of the speech synth: generates the sample-rate
// strobe, holds period/amplitude, and applies new parameter sets only at pitch-period
// boundaries (SOURCE period_done) so waveform periods never break mid-cycle. Sits between
// the phoneme/frame sequencer (valid/ready parameter stream) and SOURCE.
//
// PARAMETERS
// CLK_DIV      1000  clk cycles per sample strobe (10 MHz clk -> 10 kHz); must be >= 4
// STROBE_HIGH  2     cycles src_strobe stays high per sample; 1 <= STROBE_HIGH < CLK_DIV/2
// RAMP_SHIFT   4     amplitude ramp step = (target - current) >>> RAMP_SHIFT per sample
//
// PORTS
// clk             in   1   system clock
// rst             in   1   asynchronous reset, active high
// par_valid       in   1   parameter set offered
// par_ready       out  1   parameter set accepted when par_valid & par_ready
// par_period      in   8   samples per pitch period; 0 = noise
// par_amplitude   in   15  unsigned target amplitude
// par_duration    in   8   segment length in src_period_done pulses; 0 treated as 1
// src_strobe      out  1   sample strobe to SOURCE
// src_period      out  8   period to SOURCE
// src_amplitude   out  15  amplitude to SOURCE
// src_period_done in   1   single-cycle pulse from SOURCE at end of period
// busy            out  1   segment playing or pending
// underrun        out  1   1-cycle pulse: segment ended with no pending set
//
// BEHAVIOUR
// - Reset values: src_strobe=0, src_period=0, src_amplitude=0, par_ready=1, busy=0,
//   underrun=0; divider=0, remaining=0, pending empty, target=0.
// - Divider: free-running 0..CLK_DIV-1; src_strobe=1 when divider < STROBE_HIGH (registered).
//   Runs always, including idle (SOURCE keeps emitting silence / period_done pulses).
// - Pending buffer, 1 deep: par_ready = !pend_valid. Handshake captures period,
//   amplitude, duration; pend_valid set. No bypass: a set is never loaded in its accept cycle.
// - On src_period_done:
//     remaining > 1          -> remaining-1
//     remaining <= 1, pending -> src_period=pend period, target=pend amplitude,
//                                remaining=max(duration,1), pend_valid cleared
//     remaining == 1, none   -> target=0, remaining=0, underrun pulse; src_period held
//     remaining == 0, none   -> no change
// - Accept and load-boundary in same cycle with pending empty: set goes to pending, loads at
//   next src_period_done (segment end acts as the none case: underrun pulses).
// - busy = pend_valid | (remaining != 0).
// - Amplitude update once per sample, at divider == CLK_DIV/2 (stable before next strobe):
//   d = target - current (16-bit signed); if |d| < 2^RAMP_SHIFT current=target, else
//   current += d >>> RAMP_SHIFT. Result always within 0..32767; no wrap.
// - src_period changes only on the cycle after src_period_done; never between.
// - rst mid-segment: all state returns to reset values immediately; pending set discarded.
//
// CONFIGURATION
// SOURCE_CTRL_RAMP_EN defined: amplitude ramps as above (click-free segment changes).
// Not defined: src_amplitude = target, updated in the same cycle as target (step change);
// RAMP_SHIFT unused.
//
// TESTING (CLK_DIV=8, STROBE_HIGH=2, RAMP_SHIFT=2)
// 1 reset -> all outputs 0, par_ready=1; src_strobe high 2 of every 8 clks after release.
// 2 offer {period 20, amp 1000, dur 3}; model pulses period_done -> par_ready drops 1 cycle
//   after accept; src_period=20 cycle after next period_done; busy falls and underrun pulses
//   after 3rd further period_done; target returns to 0.
// 3 back-to-back sets {20,1000,2},{0,500,1}: second accepted while first plays; src_period
//   20 -> 0 exactly on the boundary after 2 done pulses, no underrun between segments.
// 4 RAMP_EN, target 0->1000: src_amplitude 250,437,577,... reaches 1000 via snap; no overshoot.
// 5 without RAMP_EN: src_amplitude 0 -> 1000 in the load cycle.
// 6 assert rst mid-segment with pending set -> outputs to reset values same cycle; pending lost.

Source files
------------

// File: rtl/source_ctrl.sv
// -----------------------------------------------------------------------------
// source_ctrl
//
// Drives the SOURCE excitation generator. It generates the sample-rate strobe,
// holds the current period and amplitude, and buffers one parameter set from
// the frame sequencer. A buffered set is applied only at a pitch-period
// boundary (src_period_done), so a waveform period is never cut short.
//
// Optional feature macro: SOURCE_CTRL_RAMP_EN
//   defined     : src_amplitude ramps towards the target once per sample
//                 (step = (target - current) >>> RAMP_SHIFT, snapping when
//                 close), giving click-free segment changes.
//   not defined : src_amplitude follows the target directly (step change).
//
// Parameters
//   CLK_DIV      clk cycles per sample strobe (>= 4)
//   STROBE_HIGH  cycles src_strobe stays high per sample (1 .. CLK_DIV/2-1)
//   RAMP_SHIFT   amplitude ramp shift (ramp build only)
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   par_valid/ready   parameter stream handshake (transfer when both high)
//   par_period        samples per pitch period, 0 = noise
//   par_amplitude     unsigned target amplitude
//   par_duration      segment length in period_done pulses (0 behaves as 1)
//   src_strobe        sample strobe to SOURCE
//   src_period        period to SOURCE
//   src_amplitude     amplitude to SOURCE
//   src_period_done   one-cycle pulse from SOURCE at the end of each period
//   busy              a segment is playing or a set is pending
//   underrun          one-cycle pulse: a segment ended with nothing pending
//
// Handshake: a set transfers on a clock edge where par_valid and par_ready
// are both high; par_ready is high exactly when the pending buffer is empty.
// A set is never loaded in its own accept cycle.
// -----------------------------------------------------------------------------
module source_ctrl #(
  parameter int CLK_DIV     = 1000,
  parameter int STROBE_HIGH = 2,
  parameter int RAMP_SHIFT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        par_valid,
  output logic        par_ready,
  input  logic [7:0]  par_period,
  input  logic [14:0] par_amplitude,
  input  logic [7:0]  par_duration,
  output logic        src_strobe,
  output logic [7:0]  src_period,
  output logic [14:0] src_amplitude,
  input  logic        src_period_done,
  output logic        busy,
  output logic        underrun
);

  localparam int DIV_W = $clog2(CLK_DIV);

  // Sample divider and strobe
  logic [DIV_W-1:0] div_q, div_d;
  logic             strobe_q, strobe_d;

  // Segment state
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  period_q, period_d;
  logic [14:0] target_q, target_d;
  logic        under_q, under_d;

  // One-deep pending buffer
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  pend_period_q, pend_period_d;
  logic [14:0] pend_amp_q, pend_amp_d;
  logic [7:0]  pend_dur_q, pend_dur_d;

  logic accept;

  assign accept = par_valid & ~pend_valid_q;

  always_comb begin
    div_d    = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
    strobe_d = (div_q < DIV_W'(STROBE_HIGH));
  end

  always_comb begin
    rem_d         = rem_q;
    period_d      = period_q;
    target_d      = target_q;
    under_d       = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_period_d = pend_period_q;
    pend_amp_d    = pend_amp_q;
    pend_dur_d    = pend_dur_q;

    // Boundary decisions use the registered pending flag, so a set accepted
    // on this same edge is not seen until the next boundary.
    if (src_period_done) begin
      if (rem_q > 8'd1) begin
        rem_d = rem_q - 8'd1;
      end else if (pend_valid_q) begin
        period_d     = pend_period_q;
        target_d     = pend_amp_q;
        rem_d        = (pend_dur_q == 8'd0) ? 8'd1 : pend_dur_q;
        pend_valid_d = 1'b0;
      end else if (rem_q == 8'd1) begin
        target_d = '0;
        rem_d    = '0;
        under_d  = 1'b1;
      end
    end

    // accept implies the buffer was empty, so it never collides with a load.
    if (accept) begin
      pend_valid_d  = 1'b1;
      pend_period_d = par_period;
      pend_amp_d    = par_amplitude;
      pend_dur_d    = par_duration;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      strobe_q      <= 1'b0;
      rem_q         <= '0;
      period_q      <= '0;
      target_q      <= '0;
      under_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_period_q <= '0;
      pend_amp_q    <= '0;
      pend_dur_q    <= '0;
    end else begin
      div_q         <= div_d;
      strobe_q      <= strobe_d;
      rem_q         <= rem_d;
      period_q      <= period_d;
      target_q      <= target_d;
      under_q       <= under_d;
      pend_valid_q  <= pend_valid_d;
      pend_period_q <= pend_period_d;
      pend_amp_q    <= pend_amp_d;
      pend_dur_q    <= pend_dur_d;
    end
  end

`ifdef SOURCE_CTRL_RAMP_EN
  localparam int SNAP = 1 << RAMP_SHIFT;

  logic [14:0]        amp_q, amp_d;
  logic signed [15:0] diff;
  logic [15:0]        mag;

  // Updated mid-sample so the new value is settled before the next strobe.
  // The arithmetic shift rounds towards -inf, so a falling ramp never
  // undershoots the target and a rising one never overshoots it.
  always_comb begin
    diff  = $signed({1'b0, target_q}) - $signed({1'b0, amp_q});
    mag   = diff[15] ? 16'(-diff) : 16'(diff);
    amp_d = amp_q;
    if (div_q == DIV_W'(CLK_DIV / 2)) begin
      amp_d = (mag < 16'(SNAP)) ? target_q : amp_q + 15'(diff >>> RAMP_SHIFT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) amp_q <= '0;
    else     amp_q <= amp_d;
  end

  assign src_amplitude = amp_q;
`else
  assign src_amplitude = target_q;
`endif

  assign src_strobe = strobe_q;
  assign src_period = period_q;
  assign par_ready  = ~pend_valid_q;
  assign busy       = pend_valid_q | (rem_q != 8'd0);
  assign underrun   = under_q;

endmodule
